// File: rtl/iob_cache_write_channel_axi_burst_if.sv
// AXI4 write-address, write-data and write-response channels between the
// cache write channel (master) and the interconnect (slave).
interface iob_cache_write_channel_axi_burst_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 1,
    parameter int unsigned LEN_W  = 8
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [LEN_W-1:0]    awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/iob_cache_write_channel_axi_burst.sv
// Writes one cache line per request to AXI4 as a single INCR burst, with
// concurrent AW/W issue and bounded retry on error responses.
module iob_cache_write_channel_axi_burst #(
    parameter int unsigned          BE_ADDR_W            = 32,
    parameter int unsigned          BE_DATA_W            = 64,
    parameter int unsigned          LINE_BEATS           = 4,
    parameter int unsigned          AXI_ID_W             = 1,
    parameter logic [AXI_ID_W-1:0]  AXI_ID               = '0,
    parameter int unsigned          AXI_LEN_W            = 8,
    parameter int unsigned          MAX_RETRY            = 3,
    parameter logic [3:0]           CACHE_AXI_CACHE_MODE = 4'b0011
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                valid_i,
    input  logic [BE_ADDR_W-1:0]                addr_i,
    input  logic [LINE_BEATS*BE_DATA_W-1:0]     wdata_i,
    input  logic [LINE_BEATS*BE_DATA_W/8-1:0]   wstrb_i,
    input  logic [3:0]                          acache_i,
    output logic                                ready_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                error_o,
    iob_cache_write_channel_axi_burst_if.master axi
);
    localparam int unsigned STRB_W     = BE_DATA_W / 8;
    localparam int unsigned BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int unsigned RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned LINE_BYTES = LINE_BEATS * STRB_W;

    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
    localparam logic [RETRY_W-1:0]   RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [BE_ADDR_W-1:0] ADDR_MASK = ~BE_ADDR_W'(LINE_BYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [3:0]          awcache_q;

    logic                accept_c, load_beat_c;
    logic                aw_hs_c, w_hs_c, b_hs_c;

    logic [BE_ADDR_W-1:0] awaddr_q;
    logic [BE_DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0]    wstrb_q;
    logic                 wlast_q;
    logic [BE_DATA_W-1:0] line_data_q [LINE_BEATS];
    logic [STRB_W-1:0]    line_strb_q [LINE_BEATS];

    wire unused_bid = ^axi.bid;

    assign accept_c = (state_q == IDLE) & valid_i;
    assign aw_hs_c  = awvalid_q & axi.awready;
    assign w_hs_c   = wvalid_q & axi.wready;
    assign b_hs_c   = bready_q & axi.bvalid;

    // State and control registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            retry_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            awcache_q <= CACHE_AXI_CACHE_MODE;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            retry_q   <= retry_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            if (accept_c) awcache_q <= acache_i;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        retry_d     = retry_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = 1'b0;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        load_beat_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (valid_i) begin
                    state_d   = XFER;
                    ready_d   = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    beat_d    = '0;
                    retry_d   = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            XFER: begin
                if (aw_hs_c) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs_c) begin
                    if (beat_q == LAST_BEAT) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end else begin
                        beat_d      = beat_q + BEAT_W'(1);
                        load_beat_c = 1'b1;
                    end
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = RESP;
                    bready_d = 1'b1;
                end
            end
            RESP: begin
                bready_d = 1'b1;
                if (b_hs_c) begin
                    bready_d = 1'b0;
                    if (axi.bresp == 2'b00) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end else if (retry_q < RETRY_MAX) begin
                        // Replay the latched line from beat 0
                        retry_d     = retry_q + RETRY_W'(1);
                        beat_d      = '0;
                        aw_done_d   = 1'b0;
                        w_done_d    = 1'b0;
                        awvalid_d   = 1'b1;
                        wvalid_d    = 1'b1;
                        load_beat_c = 1'b1;
                        state_d     = XFER;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Line storage and the registered W beat presented on the bus
    always_ff @(posedge clk_i) begin
        if (accept_c) begin
            awaddr_q <= addr_i & ADDR_MASK;
            for (int i = 0; i < LINE_BEATS; i++) begin
                line_data_q[i] <= wdata_i[i*BE_DATA_W +: BE_DATA_W];
                line_strb_q[i] <= wstrb_i[i*STRB_W +: STRB_W];
            end
            wdata_q <= wdata_i[BE_DATA_W-1:0];
            wstrb_q <= wstrb_i[STRB_W-1:0];
            wlast_q <= (LINE_BEATS == 1);
        end else if (load_beat_c) begin
            wdata_q <= line_data_q[beat_d];
            wstrb_q <= line_strb_q[beat_d];
            wlast_q <= (beat_d == LAST_BEAT);
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign error_o = error_q;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = AXI_LEN_W'(LINE_BEATS - 1);
    assign axi.awsize  = 3'($clog2(STRB_W));
    assign axi.awburst = (LINE_BEATS > 1) ? 2'b01 : 2'b00;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = awcache_q;
    assign axi.awprot  = 3'b000;
    assign axi.awqos   = 4'b0000;
    assign axi.awvalid = awvalid_q;

    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = wlast_q;
    assign axi.wvalid  = wvalid_q;

    assign axi.bready  = bready_q;
endmodule

// File: tb/tb_iob_cache_write_channel_axi_burst.sv
// Scoreboard bench: requests push expected AW/W/status items, an AXI slave
// model answers, and a monitor pops and compares as the DUT presents them.
module tb_iob_cache_write_channel_axi_burst;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned BEATS      = 4;
    localparam int unsigned STRB_W     = DATA_W / 8;
    localparam int unsigned LINE_BYTES = BEATS * STRB_W;
    localparam int unsigned MAX_RETRY  = 3;

    typedef struct { logic [ADDR_W-1:0] addr; logic [3:0] cache; } aw_exp_t;
    typedef struct { logic [DATA_W-1:0] data; logic [STRB_W-1:0] strb; logic last; } w_exp_t;

    logic                      clk = 1'b0;
    logic                      reset_i;
    logic                      valid_i;
    logic [ADDR_W-1:0]         addr_i;
    logic [BEATS*DATA_W-1:0]   wdata_i;
    logic [BEATS*STRB_W-1:0]   wstrb_i;
    logic [3:0]                acache_i;
    logic                      ready_o, busy_o, done_o, error_o;

    iob_cache_write_channel_axi_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(1), .LEN_W(8)) axi ();

    iob_cache_write_channel_axi_burst #(
        .BE_ADDR_W(ADDR_W), .BE_DATA_W(DATA_W), .LINE_BEATS(BEATS), .AXI_ID_W(1),
        .AXI_ID(1'b0), .AXI_LEN_W(8), .MAX_RETRY(MAX_RETRY), .CACHE_AXI_CACHE_MODE(4'b0011)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .acache_i(acache_i),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .axi(axi)
    );

    always #5 clk = ~clk;

    aw_exp_t     exp_aw_q[$];
    w_exp_t      exp_w_q[$];
    bit          exp_st_q[$];
    logic [1:0]  bresp_plan_q[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  aw_bursts = 0;
    bit  chk_en = 1'b0;
    int  aw_stall = 0;
    bit  aw_rand = 1'b0;
    int  w_mode = 0;
    int  w_phase = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name, input string detail);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s at %0t", name, detail, $time);
    endtask

    // AXI slave model: ready generation and B responses from the planned list
    initial begin
        bit s_aw, s_wl, s_b, s_rst;
        int aw_out = 0, w_out = 0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 1'b0;
        forever begin
            @(negedge clk);
            s_aw  = axi.awvalid & axi.awready;
            s_wl  = axi.wvalid & axi.wready & axi.wlast;
            s_b   = axi.bvalid & axi.bready;
            s_rst = reset_i;
            @(posedge clk);
            #1;
            if (s_rst) begin
                aw_out = 0; w_out = 0; axi.bvalid = 1'b0;
            end else begin
                if (s_aw) aw_out++;
                if (s_wl) w_out++;
                if (s_b) begin
                    axi.bvalid = 1'b0; aw_out--; w_out--;
                end
            end
            if (aw_stall > 0) begin
                axi.awready = 1'b0; aw_stall--;
            end else begin
                axi.awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            case (w_mode)
                1:       axi.wready = 1'($urandom_range(0, 1));
                2:       begin axi.wready = (w_phase % 3 == 0); w_phase++; end
                default: axi.wready = 1'b1;
            endcase
            if (!axi.bvalid && aw_out > 0 && w_out > 0 && bresp_plan_q.size() > 0) begin
                axi.bvalid = 1'b1;
                axi.bresp  = bresp_plan_q.pop_front();
                axi.bid    = 1'($urandom);
            end
        end
    end

    // Monitor: compares every presented AW/W item and status pulse with the queue heads
    initial begin
        bit aw_pend = 0, w_pend = 0, aw_seen = 0, w_seen = 0, st;
        forever begin
            @(negedge clk);
            if (reset_i || !chk_en) begin
                aw_pend = 0; w_pend = 0; aw_seen = 0; w_seen = 0;
                continue;
            end
            if (axi.awvalid) begin
                if (exp_aw_q.size() == 0) flag_fail("aw_unexpected", "awvalid with no burst expected");
                else begin
                    check("awaddr", 64'(axi.awaddr), 64'(exp_aw_q[0].addr));
                    check("awcache", 64'(axi.awcache), 64'(exp_aw_q[0].cache));
                    check("awlen", 64'(axi.awlen), 64'(BEATS - 1));
                    check("awsize", 64'(axi.awsize), 64'($clog2(STRB_W)));
                    check("awburst", 64'(axi.awburst), 64'(2'b01));
                    if (axi.awready) begin
                        void'(exp_aw_q.pop_front());
                        aw_bursts++; aw_seen = 1; aw_pend = 0;
                    end else aw_pend = 1;
                end
            end else if (aw_pend) begin
                flag_fail("awvalid_drop", "awvalid dropped before handshake");
                aw_pend = 0;
            end
            if (axi.wvalid) begin
                if (exp_w_q.size() == 0) flag_fail("w_unexpected", "wvalid with no beat expected");
                else begin
                    check("wdata", 64'(axi.wdata), 64'(exp_w_q[0].data));
                    check("wstrb", 64'(axi.wstrb), 64'(exp_w_q[0].strb));
                    check("wlast", 64'(axi.wlast), 64'(exp_w_q[0].last));
                    if (axi.wready) begin
                        if (exp_w_q[0].last) w_seen = 1;
                        void'(exp_w_q.pop_front());
                        w_pend = 0;
                    end else w_pend = 1;
                end
            end else if (w_pend) begin
                flag_fail("wvalid_drop", "wvalid dropped before handshake");
                w_pend = 0;
            end
            if (axi.bready) begin
                check("bready_after_aw_w", 64'({aw_seen, w_seen}), 64'(2'b11));
                if (axi.bvalid) begin aw_seen = 0; w_seen = 0; end
            end
            if (done_o || error_o) begin
                if (exp_st_q.size() == 0) flag_fail("status_unexpected", "done/error pulse with none expected");
                else begin
                    st = exp_st_q.pop_front();
                    check("done_o", 64'(done_o), 64'(st));
                    check("error_o", 64'(error_o), 64'(!st));
                    check("ready_with_status", 64'(ready_o), 64'(1));
                end
            end
        end
    end

    // Drives one request; expectations are derived from the number of error responses.
    task automatic issue(input logic [ADDR_W-1:0] addr, input logic [BEATS*DATA_W-1:0] line,
                         input logic [BEATS*STRB_W-1:0] strb, input logic [3:0] cache,
                         input int n_err, input int stall);
        bit ok;
        int nb;
        bit got;
        ok = (n_err <= MAX_RETRY);
        nb = ok ? n_err + 1 : MAX_RETRY + 1;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready_o) begin got = 1; break; end
        end
        if (!got) flag_fail("ready_timeout", "ready_o never high");
        aw_stall = stall;
        valid_i = 1'b1; addr_i = addr; wdata_i = line; wstrb_i = strb; acache_i = cache;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        addr_i = $urandom; wdata_i = {8{$urandom}}; wstrb_i = $urandom; acache_i = 4'($urandom);
        for (int b = 0; b < nb; b++) begin
            exp_aw_q.push_back('{addr: addr & ~ADDR_W'(LINE_BYTES - 1), cache: cache});
            for (int k = 0; k < BEATS; k++)
                exp_w_q.push_back('{data: line[k*DATA_W +: DATA_W], strb: strb[k*STRB_W +: STRB_W],
                                    last: (k == BEATS - 1)});
            bresp_plan_q.push_back((b == nb - 1 && ok) ? 2'b00 : 2'($urandom_range(2, 3)));
        end
        exp_st_q.push_back(ok);
    endtask

    task automatic wait_done();
        bit fin = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (exp_st_q.size() == 0 && exp_aw_q.size() == 0 && exp_w_q.size() == 0 && ready_o) begin
                fin = 1; break;
            end
        end
        if (!fin) flag_fail("done_timeout", "request did not complete");
    endtask

    initial begin
        logic [BEATS*DATA_W-1:0] line;
        logic [BEATS*STRB_W-1:0] strb;
        logic [DATA_W-1:0] pat;
        int lat, b0;
        bit hit;

        reset_i = 1'b1; valid_i = 1'b0; addr_i = '0; wdata_i = '0; wstrb_i = '0; acache_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'(1));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_error", 64'(error_o), 64'(0));
        check("rst_awvalid", 64'(axi.awvalid), 64'(0));
        check("rst_wvalid", 64'(axi.wvalid), 64'(0));
        check("rst_bready", 64'(axi.bready), 64'(0));
        check("rst_awcache", 64'(axi.awcache), 64'(4'b0011));
        reset_i = 1'b0;
        chk_en = 1'b1;

        // Basic line, all readies high, with best-case latency
        pat = 64'h1111_1111_1111_1111;
        for (int k = 0; k < BEATS; k++) line[k*DATA_W +: DATA_W] = pat * 64'(k + 1);
        strb = '1;
        issue(32'h1000_0024, line, strb, 4'hF, 0, 0);
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done_o) begin lat = k; break; end
        end
        check("latency", 64'(lat), 64'(BEATS + 2));
        wait_done();

        // AW backpressure
        issue(32'h2000_0040, line, {8'h0F, 8'hF0, 8'h33, 8'hCC}, 4'h2, 0, 6);
        wait_done();

        // W backpressure, ready pattern 1,0,0
        w_mode = 2; w_phase = 0;
        issue(32'h3000_0008, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              32'h5A5A_A5A5, 4'h7, 0, 0);
        wait_done();
        w_mode = 0;

        // One error response then OKAY
        b0 = aw_bursts;
        issue(32'h4000_1234, line, strb, 4'h3, 1, 0);
        wait_done();
        check("retry_bursts", 64'(aw_bursts - b0), 64'(2));

        // Errors until retries are exhausted
        b0 = aw_bursts;
        issue(32'h5000_00FF, line, strb, 4'h3, 99, 0);
        wait_done();
        check("exhaust_bursts", 64'(aw_bursts - b0), 64'(MAX_RETRY + 1));

        // Reset while beat 2 is on the bus
        issue(32'h6000_0000, line, strb, 4'h3, 0, 0);
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (axi.wvalid && axi.wdata == line[2*DATA_W +: DATA_W]) begin hit = 1; break; end
        end
        if (!hit) flag_fail("beat2_timeout", "beat 2 never presented");
        #2;
        chk_en = 1'b0;
        reset_i = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_awvalid", 64'(axi.awvalid), 64'(0));
        check("mid_rst_wvalid", 64'(axi.wvalid), 64'(0));
        check("mid_rst_bready", 64'(axi.bready), 64'(0));
        check("mid_rst_ready", 64'(ready_o), 64'(1));
        check("mid_rst_busy", 64'(busy_o), 64'(0));
        exp_aw_q.delete(); exp_w_q.delete(); exp_st_q.delete(); bresp_plan_q.delete();
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        b0 = aw_bursts;
        issue(32'h6100_0010, line, strb, 4'h1, 3, 0);
        wait_done();
        check("post_rst_bursts", 64'(aw_bursts - b0), 64'(4));

        // Randomised requests and backpressure
        aw_rand = 1'b1; w_mode = 1;
        for (int r = 0; r < 16; r++) begin
            issue($urandom, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                  $urandom, 4'($urandom), $urandom_range(0, 4), 0);
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
